// File: rtl/button_conditioner_pkg.sv
// Shared constants for the paddle-button front end: channel indices and the
// per-channel auto-repeat state encoding.
package button_conditioner_pkg;

    localparam int BTN_P1L = 0;
    localparam int BTN_P1R = 1;
    localparam int BTN_P2L = 2;
    localparam int BTN_P2R = 3;

    localparam int N_BTN_DEFAULT = BTN_P2R + 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        HELD_DELAY = 2'd1,
        HELD_RATE  = 2'd2
    } btn_state_e;

endpackage

// File: rtl/button_channel.sv
// One button: 2-FF synchroniser, polarity normalise, debounce counter and the
// press/hold auto-repeat FSM. All outputs are registered.
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
    localparam logic             RAW_IDLE   = ACTIVE_LOW;

    logic             sync1_q, sync2_q;
    logic             s;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             level_q, level_d;
    logic             press_q, release_q, repeat_q, repeat_d;
    logic             rise, fall;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    btn_state_e       state_q, state_d;

    // Sync flops reset to the released pin level so a button held through
    // reset is seen as a fresh press once reset lifts.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= RAW_IDLE;
            sync2_q <= RAW_IDLE;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q ^ ACTIVE_LOW;

    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        if (s != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d  = s;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    // Release wins over everything so no repeat can fire in the release cycle.
    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        repeat_d  = 1'b0;
        if (fall) begin
            state_d   = IDLE;
            rep_cnt_d = '0;
        end else if (rise) begin
            state_d   = HELD_DELAY;
            rep_cnt_d = '0;
            repeat_d  = 1'b1;
        end else begin
            case (state_q)
                HELD_DELAY: begin
                    if (rep_cnt_q == DELAY_LAST) begin
                        state_d   = HELD_RATE;
                        rep_cnt_d = '0;
                        repeat_d  = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + CNT_W'(1);
                    end
                end
                HELD_RATE: begin
                    if (rep_cnt_q == RATE_LAST) begin
                        rep_cnt_d = '0;
                        repeat_d  = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d   = IDLE;
                    rep_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            rep_cnt_q <= '0;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= rise;
            release_q <= fall;
            repeat_q  <= repeat_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// Paddle-button front end: one independent button_channel per raw pin
// (bit0=p1l, bit1=p1r, bit2=p2l, bit3=p2r).
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEFAULT,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
            button_channel #(
                .ACTIVE_LOW     (ACTIVE_LOW),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_RATE    (REPEAT_RATE),
                .CNT_W          (CNT_W)
            ) u_chan (
                .clk      (clk),
                .reset    (reset),
                .raw_i    (btn_raw[gi]),
                .level_o  (btn_level[gi]),
                .press_o  (btn_press[gi]),
                .release_o(btn_release[gi]),
                .repeat_o (btn_repeat[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: each scenario pushes its expected per-cycle output timeline
// when it drives the pins; a monitor pops and compares one entry per cycle.
module tb_button_conditioner;

    logic       clk;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] btn_level, btn_press, btn_release, btn_repeat;

    button_conditioner #(
        .N_BTN          (4),
        .ACTIVE_LOW     (1'b1),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_RATE    (3),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       tag;
        logic [15:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int       cyc    = 0;
    int       checks = 0;
    int       errors = 0;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    function automatic logic [15:0] vec(input logic [3:0] l, input logic [3:0] p,
                                        input logic [3:0] r, input logic [3:0] q);
        return {l, p, r, q};
    endfunction

    function automatic void push(input int c, input string tag, input logic [15:0] e);
        sb_item_t it;
        it.cyc = c;
        it.tag = $sformatf("%s@%0d", tag, c);
        it.exp = e;
        sb.push_back(it);
    endfunction

    // Monitor: outputs are sampled 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                sb_item_t it;
                it = sb.pop_front();
                check_eq(it.tag, {btn_level, btn_press, btn_release, btn_repeat}, it.exp);
            end
        end
    end

    task automatic step_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset   = 1'b0;
        btn_raw = 4'hF;
        push(cyc + 1, "reset", 16'h0000);
        @(posedge clk);
        #2;
        reset = 1'b1;
        step_to(cyc + 10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        logic [3:0] l, p, r, q;
        reset   = 1'b0;
        btn_raw = 4'hF;
        do_reset();

        // Clean press on p1l, held, auto-repeat, then released at cycle 30.
        t0 = cyc;
        btn_raw[0] = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            l = {3'b0, (k >= 6 && k < 36)};
            p = {3'b0, (k == 6)};
            r = {3'b0, (k == 36)};
            q = {3'b0, (k == 6) || (k >= 16 && k < 36 && ((k - 16) % 3) == 0)};
            push(t0 + k, "press_hold", vec(l, p, r, q));
        end
        step_to(t0 + 30);
        btn_raw[0] = 1'b1;
        step_to(t0 + 45);
        do_reset();

        // Bounce on p1r: last transition to pressed is at cycle 4, so level follows 6 later.
        t0 = cyc;
        btn_raw[1] = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            l = {2'b0, (k >= 10 && k < 22), 1'b0};
            p = {2'b0, (k == 10), 1'b0};
            r = {2'b0, (k == 22), 1'b0};
            q = {2'b0, (k == 10 || k == 20), 1'b0};
            push(t0 + k, "bounce", vec(l, p, r, q));
        end
        step_to(t0 + 1); btn_raw[1] = 1'b1;
        step_to(t0 + 2); btn_raw[1] = 1'b0;
        step_to(t0 + 3); btn_raw[1] = 1'b1;
        step_to(t0 + 4); btn_raw[1] = 1'b0;
        step_to(t0 + 16); btn_raw[1] = 1'b1;
        step_to(t0 + 24);
        do_reset();

        // All four together, then reset mid HELD_RATE with buttons still held.
        t0 = cyc;
        btn_raw = 4'h0;
        for (int k = 1; k <= 30; k++) begin
            if (k < 21) begin
                l = (k >= 6) ? 4'hF : 4'h0;
                p = (k == 6) ? 4'hF : 4'h0;
                q = (k == 6 || k == 16 || k == 19) ? 4'hF : 4'h0;
            end else begin
                l = (k >= 27) ? 4'hF : 4'h0;
                p = (k == 27) ? 4'hF : 4'h0;
                q = (k == 27) ? 4'hF : 4'h0;
            end
            push(t0 + k, "simul_reset", vec(l, p, 4'h0, q));
        end
        step_to(t0 + 20);
        reset = 1'b0;
        step_to(t0 + 21);
        reset = 1'b1;
        step_to(t0 + 30);
        do_reset();

        // 3-cycle glitch on p2r must be rejected.
        t0 = cyc;
        btn_raw[3] = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            push(t0 + k, "glitch", 16'h0000);
        end
        step_to(t0 + 3);
        btn_raw[3] = 1'b1;
        step_to(t0 + 15);

        step_to(cyc + 3);
        check_eq("sb_drain", 16'(sb.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
